// File: rtl/oram_path_fetch.sv
// Path ORAM path-read stage: walks root-to-leaf, reads one bucket per level, streams valid tuples.
// Optional CLEAR_ON_READ_EN: wipes each bucket right after it is scanned. Defaults mirror common_defs_pkg.
module oram_path_fetch #(
    parameter int unsigned TREE_DEPTH = 12,
    parameter int unsigned K          = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NODE_AW    = TREE_DEPTH + 1,
    parameter int unsigned TW         = 1 + 2 * TREE_DEPTH + DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [TREE_DEPTH-1:0] req_leaf,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [NODE_AW-1:0]    mem_addr,
    output logic [K*TW-1:0]       mem_wr_data,
    input  logic [K*TW-1:0]       mem_rd_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic [TREE_DEPTH-1:0] st_blk_id,
    output logic [TREE_DEPTH-1:0] st_leaf,
    output logic [DATA_WIDTH-1:0] st_data,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LW = $clog2(TREE_DEPTH + 1);
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StScan,
`ifdef CLEAR_ON_READ_EN
        StClear,
`endif
        StDone
    } state_e;

    // Heap-ordered node index of the path node at level lvl.
    function automatic logic [NODE_AW-1:0] node_addr(input logic [LW-1:0]         lvl,
                                                      input logic [TREE_DEPTH-1:0] leaf);
        logic [NODE_AW-1:0] base;
        logic [NODE_AW-1:0] off;
        base = (NODE_AW'(1) << lvl) - NODE_AW'(1);
        off  = NODE_AW'(leaf >> (LW'(TREE_DEPTH) - lvl));
        return base + off;
    endfunction

    state_e                  state_q, state_d;
    logic [LW-1:0]           level_q, level_d;
    logic [KW-1:0]           k_q, k_d;
    logic [TREE_DEPTH-1:0]   leaf_q, leaf_d;
    logic [K*TW-1:0]         bucket_q, bucket_d;
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic [NODE_AW-1:0]      mem_addr_q, mem_addr_d;
    logic                    st_valid_q, st_valid_d;
    logic [TREE_DEPTH-1:0]   st_blk_id_q, st_blk_id_d;
    logic [TREE_DEPTH-1:0]   st_leaf_q, st_leaf_d;
    logic [DATA_WIDTH-1:0]   st_data_q, st_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    level_end;
    logic [TW-1:0]           tuple_d;
`ifdef CLEAR_ON_READ_EN
    logic                    mem_wr_en_q, mem_wr_en_d;
`endif

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        k_d         = k_q;
        leaf_d      = leaf_q;
        bucket_d    = bucket_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        done_d      = 1'b0;
        level_end   = 1'b0;
`ifdef CLEAR_ON_READ_EN
        mem_wr_en_d = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    leaf_d      = req_leaf;
                    level_d     = '0;
                    state_d     = StRead;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = node_addr('0, req_leaf);
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                bucket_d = mem_rd_data;
                k_d      = '0;
                state_d  = StScan;
            end
            StScan: begin
                // A presented tuple blocks until the stash takes it; empty slots fall through.
                if (!st_valid_q || st_ready) begin
                    if (k_q == KW'(K - 1)) begin
`ifdef CLEAR_ON_READ_EN
                        state_d     = StClear;
                        mem_wr_en_d = 1'b1;
`else
                        level_end   = 1'b1;
`endif
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
`ifdef CLEAR_ON_READ_EN
            StClear: level_end = 1'b1;
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (level_end) begin
            if (level_q == LW'(TREE_DEPTH)) begin
                state_d = StDone;
                done_d  = 1'b1;
            end else begin
                level_d     = level_q + LW'(1);
                state_d     = StRead;
                mem_rd_en_d = 1'b1;
                mem_addr_d  = node_addr(level_q + LW'(1), leaf_q);
            end
        end

        tuple_d     = bucket_d[int'(k_d) * TW +: TW];
        st_valid_d  = (state_d == StScan) && tuple_d[TW-1];
        st_blk_id_d = st_valid_d ? tuple_d[TW-2 -: TREE_DEPTH] : '0;
        st_leaf_d   = st_valid_d ? tuple_d[DATA_WIDTH+TREE_DEPTH-1 -: TREE_DEPTH] : '0;
        st_data_d   = st_valid_d ? tuple_d[DATA_WIDTH-1:0] : '0;
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            level_q     <= '0;
            k_q         <= '0;
            leaf_q      <= '0;
            bucket_q    <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            st_valid_q  <= 1'b0;
            st_blk_id_q <= '0;
            st_leaf_q   <= '0;
            st_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CLEAR_ON_READ_EN
            mem_wr_en_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            k_q         <= k_d;
            leaf_q      <= leaf_d;
            bucket_q    <= bucket_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            st_valid_q  <= st_valid_d;
            st_blk_id_q <= st_blk_id_d;
            st_leaf_q   <= st_leaf_d;
            st_data_q   <= st_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CLEAR_ON_READ_EN
            mem_wr_en_q <= mem_wr_en_d;
`endif
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = '0;
`ifdef CLEAR_ON_READ_EN
    assign mem_wr_en   = mem_wr_en_q;
`else
    assign mem_wr_en   = 1'b0;
`endif
    assign st_valid    = st_valid_q;
    assign st_blk_id   = st_blk_id_q;
    assign st_leaf     = st_leaf_q;
    assign st_data     = st_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_oram_path_fetch.sv
// Bench for oram_path_fetch: sparse tree memory model, heap-walk path model, per-tuple stall scripts.
module tb_oram_path_fetch;

    localparam int D      = 12;
    localparam int K      = 3;
    localparam int DW     = 32;
    localparam int AW     = D + 1;
    localparam int TW     = 1 + 2 * D + DW;
    localparam int NNODES = (1 << (D + 1)) - 1;
`ifdef CLEAR_ON_READ_EN
    localparam int COST = 3 + K;
`else
    localparam int COST = 2 + K;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [D-1:0]  req_leaf;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [K*TW-1:0] mem_wr_data;
    logic [K*TW-1:0] mem_rd_data;
    logic          st_valid;
    logic          st_ready;
    logic [D-1:0]  st_blk_id;
    logic [D-1:0]  st_leaf;
    logic [DW-1:0] st_data;
    logic          busy;
    logic          done;

    oram_path_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_leaf   (req_leaf),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .st_valid   (st_valid),
        .st_ready   (st_ready),
        .st_blk_id  (st_blk_id),
        .st_leaf    (st_leaf),
        .st_data    (st_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Tree memory: contents loaded by the bench; device clears tracked per load epoch.
    logic [K*TW-1:0] tree [0:NNODES];
    int              wipe_ep [0:NNODES];
    int              epoch = 1;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= (wipe_ep[mem_addr] == epoch) ? '0 : tree[mem_addr];
        if (mem_wr_en && mem_wr_data == '0) wipe_ep[mem_addr] <= epoch;
    end

    // Monitor
    int          cyc, busy_cnt, done_cyc, unstable;
    int          rd_total = 0, done_total = 0, wr_total = 0, wrdata_nz = 0;
    bit          mon_on = 0, got_done = 0, prev_stall = 0;
    logic [TW-1:0] prev_fields;
    int          mon_reads[$], mon_rd_cyc[$], mon_wr[$], mon_wr_cyc[$];
    logic [TW-1:0] mon_xfer[$];

    always @(negedge clk) begin
        if (mem_rd_en) rd_total++;
        if (done) done_total++;
        if (mem_wr_en) wr_total++;
        if (mem_wr_data != '0) wrdata_nz++;
        if (rst) begin
            mon_on = 0;
        end else begin
            if (mon_on) begin
                cyc++;
                if (busy) busy_cnt++;
                if (mem_rd_en) begin
                    mon_reads.push_back(int'(mem_addr));
                    mon_rd_cyc.push_back(cyc);
                end
                if (mem_wr_en) begin
                    mon_wr.push_back(int'(mem_addr));
                    mon_wr_cyc.push_back(cyc);
                end
                if (prev_stall && (st_valid !== 1'b1 || {1'b1, st_blk_id, st_leaf, st_data} !== prev_fields))
                    unstable++;
                if (st_valid && st_ready) mon_xfer.push_back({1'b1, st_blk_id, st_leaf, st_data});
                prev_stall  = st_valid && !st_ready;
                prev_fields = {1'b1, st_blk_id, st_leaf, st_data};
                if (done) begin
                    got_done = 1;
                    done_cyc = cyc;
                    mon_on   = 0;
                end
            end
            if (req_valid && req_ready) begin
                mon_on = 1; cyc = 0; busy_cnt = 0; got_done = 0; prev_stall = 0; unstable = 0;
                mon_reads.delete(); mon_rd_cyc.delete(); mon_wr.delete(); mon_wr_cyc.delete();
                mon_xfer.delete();
            end
        end
    end

    // Stash side: each presented tuple is held off for the next scripted number of cycles.
    int stall_len[$];
    int cur_cnt = 0;
    initial begin
        st_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (st_valid) begin
                if (stall_len.size() > 0 && cur_cnt < stall_len[0]) begin
                    st_ready = 1'b0;
                    cur_cnt++;
                end else begin
                    st_ready = 1'b1;
                    cur_cnt  = 0;
                    if (stall_len.size() > 0) void'(stall_len.pop_front());
                end
            end else begin
                st_ready = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [TW-1:0] mk(input int blk, input int lf, input logic [31:0] data);
        logic [D-1:0] b;
        logic [D-1:0] l;
        b = D'(blk);
        l = D'(lf);
        return {1'b1, b, l, data};
    endfunction

    task automatic clear_tree();
        for (int i = 0; i <= NNODES; i++) tree[i] = '0;
        epoch++;
    endtask

    // Path node at level lvl: walk down from the root, left child on 0, right child on 1.
    function automatic int path_node(input logic [D-1:0] leaf, input int lvl);
        int n = 0;
        for (int l = 1; l <= lvl; l++) n = 2 * n + 1 + int'(leaf[D-l]);
        return n;
    endfunction

    int            exp_addr[$];
    logic [TW-1:0] exp_tup[$];

    task automatic build_expect(input logic [D-1:0] leaf, input bit force_empty);
        logic [TW-1:0] t;
        exp_addr.delete();
        exp_tup.delete();
        for (int l = 0; l <= D; l++) begin
            exp_addr.push_back(path_node(leaf, l));
            for (int k = 0; k < K; k++) begin
                t = tree[path_node(leaf, l)][k*TW +: TW];
                if (t[TW-1] && !force_empty) exp_tup.push_back(t);
            end
        end
    endtask

    task automatic start(input logic [D-1:0] leaf);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_leaf  = leaf;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_fetch(input string tag, input logic [D-1:0] leaf, input int stall_each,
                             input bit rnd_stall, input bit force_empty);
        int exp_done;
        int stall_sum = 0;
        int waited = 0;
        int s;
        build_expect(leaf, force_empty);
        stall_len.delete();
        foreach (exp_tup[i]) begin
            s = rnd_stall ? int'($urandom_range(0, 3)) : stall_each;
            stall_len.push_back(s);
            stall_sum += s;
        end
        exp_done = 1 + COST * (D + 1) + stall_sum;
        start(leaf);
        while (!got_done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " done_seen"}, 64'(got_done), 64'd1);
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_done));
        chk({tag, " n_reads"}, 64'(mon_reads.size()), 64'(exp_addr.size()));
        foreach (exp_addr[i])
            chk({tag, $sformatf(" rd_addr[%0d]", i)},
                64'(i < mon_reads.size() ? mon_reads[i] : -1), 64'(exp_addr[i]));
        chk({tag, " n_xfers"}, 64'(mon_xfer.size()), 64'(exp_tup.size()));
        foreach (exp_tup[i])
            chk({tag, $sformatf(" xfer[%0d]", i)},
                64'(i < mon_xfer.size() ? mon_xfer[i] : '0), 64'(exp_tup[i]));
        chk({tag, " stall_stable"}, 64'(unstable), 64'd0);
`ifdef CLEAR_ON_READ_EN
        chk({tag, " n_writes"}, 64'(mon_wr.size()), 64'(exp_addr.size()));
        foreach (exp_addr[i]) begin
            chk({tag, $sformatf(" wr_addr[%0d]", i)},
                64'(i < mon_wr.size() ? mon_wr[i] : -1), 64'(exp_addr[i]));
            if (stall_sum == 0)
                chk({tag, $sformatf(" wr_cyc[%0d]", i)},
                    64'(i < mon_wr_cyc.size() ? mon_wr_cyc[i] : -1), 64'(1 + i * COST + 2 + K));
        end
`else
        chk({tag, " no_writes"}, 64'(wr_total), 64'd0);
`endif
        chk({tag, " wr_data_zero"}, 64'(wrdata_nz), 64'd0);
        @(negedge clk);
        chk({tag, " idle_after"}, {62'd0, busy, req_ready}, 64'd1);
    endtask

    logic [D-1:0] rleaf;
    int           n5, rd_snap, done_snap, waited;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_leaf  = '0;
        clear_tree();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {st_blk_id, st_leaf, st_data, mem_addr},
            64'd0);
        chk("reset_ctrl", {58'd0, req_ready, mem_rd_en, mem_wr_en, st_valid, busy, done}, 64'h20);

        run_fetch("empty_leaf0", 12'h000, 0, 0, 0);
        run_fetch("empty_leafFFF", 12'hFFF, 0, 0, 0);

        clear_tree();
        tree[0][1*TW +: TW]    = mk(12'h012, 12'h345, 32'hDEADBEEF);
        tree[6747][0*TW +: TW] = mk(12'h0AA, 12'hA5C, 32'h11111111);
        tree[6747][2*TW +: TW] = mk(12'h0BB, 12'hA5C, 32'h22222222);
        run_fetch("a5c", 12'hA5C, 0, 0, 0);
        epoch++;
        run_fetch("a5c_stall", 12'hA5C, 4, 0, 0);

        for (int r = 0; r < 3; r++) begin
            clear_tree();
            rleaf = D'($urandom);
            for (int l = 0; l <= D; l++)
                for (int k = 0; k < K; k++)
                    if ($urandom_range(0, 9) < 4)
                        tree[path_node(rleaf, l)][k*TW +: TW] =
                            mk(int'($urandom), int'($urandom), $urandom);
            for (int j = 0; j < 20; j++)
                tree[$urandom_range(0, NNODES - 1)][$urandom_range(0, K - 1)*TW +: TW] =
                    mk(int'($urandom), int'($urandom), $urandom);
            run_fetch($sformatf("rand%0d", r), rleaf, 0, 1, 0);
        end

        // Reset while a tuple at level 5 is held by a stalled stash.
        clear_tree();
        rleaf = 12'h3C7;
        n5 = path_node(rleaf, 5);
        tree[n5][1*TW +: TW] = mk(12'h155, 12'h3C7, 32'hCAFEF00D);
        stall_len.delete();
        stall_len.push_back(1000);
        start(rleaf);
        waited = 0;
        while (!st_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid_stvalid", 64'(st_valid), 64'd1);
        chk("rst_mid_addr", 64'(mem_addr), 64'(n5));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_fields", {st_blk_id, st_leaf, st_data, mem_addr}, 64'd0);
        chk("rst_mid_ctrl", {58'd0, req_ready, mem_rd_en, mem_wr_en, st_valid, busy, done}, 64'h20);
        rd_snap   = rd_total;
        done_snap = done_total;
        repeat (80) @(negedge clk);
        chk("rst_mid_no_reads", 64'(rd_total), 64'(rd_snap));
        chk("rst_mid_no_done", 64'(done_total), 64'(done_snap));
        stall_len.delete();
        epoch++;
        run_fetch("after_rst", rleaf, 0, 0, 0);

`ifdef CLEAR_ON_READ_EN
        clear_tree();
        tree[0][2*TW +: TW]    = mk(12'h001, 12'h000, 32'h0000_0001);
        tree[4095][0*TW +: TW] = mk(12'h002, 12'h000, 32'h0000_0002);
        run_fetch("clr_first", 12'h000, 0, 0, 0);
        run_fetch("clr_second", 12'h000, 0, 0, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/oram_path_fetch.md
Name: oram_path_fetch

Overview:
- Path-read stage of the Path ORAM controller. Sits between the position-map lookup, which supplies the leaf label, and the stash, which receives the tuples.
- For one access it walks the tree path from the root to the given leaf and issues one bucket read per level to the tree memory.
- It unpacks the K tuples of each bucket and streams every real (valid) tuple into the stash over a valid/ready handshake.
- All sizing comes from common_defs_pkg.

Parameters:
- TREE_DEPTH, common_defs_pkg::TREE_DEPTH (12): leaf-label and block-id width. The path has TREE_DEPTH+1 levels.
- K, common_defs_pkg::K (3): tuples per bucket.
- DATA_WIDTH, ALPHA*BYTE_WIDTH (32): payload bits per tuple.
- NODE_AW, TREE_DEPTH+1 (13): tree-memory node address width.
- TW, 1+2*TREE_DEPTH+DATA_WIDTH (57): tuple width. Layout {valid, blk_id, leaf, data}, MSB first.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  path-fetch request
- req_ready  out  1  high while in IDLE
- req_leaf  in  TREE_DEPTH  leaf label to fetch
- mem_rd_en  out  1  tree-memory read strobe
- mem_wr_en  out  1  tree-memory write strobe (CLEAR_ON_READ_EN only; tied 0 otherwise)
- mem_addr  out  NODE_AW  node index
- mem_wr_data  out  K*TW  write bucket (always zero)
- mem_rd_data  in  K*TW  read bucket; valid the cycle after mem_rd_en. Tuple k is at [k*TW +: TW].
- st_valid  out  1  tuple available to the stash
- st_ready  in  1  stash accepts
- st_blk_id  out  TREE_DEPTH  block id of the presented tuple
- st_leaf  out  TREE_DEPTH  leaf label of the presented tuple
- st_data  out  DATA_WIDTH  payload of the presented tuple
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the path is complete

Behaviour:
- States: IDLE, READ, WAIT, SCAN, CLEAR (feature only), DONE.
- Reset: state=IDLE, level=0, k=0, bucket register=0.
  - Registered outputs reset to 0: mem_rd_en, mem_wr_en, mem_addr, st_*, busy, done.
  - req_ready=1 from the first cycle after reset.
- IDLE:
  - req_valid && req_ready latches req_leaf, sets level=0, goes to READ.
  - req_valid is ignored in every other state.
- READ:
  - mem_rd_en=1 for exactly one cycle.
  - mem_addr = (2^level − 1) + (leaf >> (TREE_DEPTH − level)), computed at NODE_AW width, no overflow. Level 0 gives address 0; level TREE_DEPTH gives 2^TREE_DEPTH − 1 + leaf.
  - Goes to WAIT.
- WAIT: latches mem_rd_data into the bucket register, sets k=0, goes to SCAN.
- SCAN (one tuple index k per visit):
  - Tuple k invalid: skipped in one cycle, st_valid=0.
  - Tuple k valid: st_valid=1 with its fields; the block holds until st_ready. The transfer completes in the cycle where st_valid && st_ready; k advances on the next edge.
  - st_* fields are stable while st_valid=1 && st_ready=0.
  - After k=K−1: goes to CLEAR if the feature is on, otherwise to the next level.
- Next level: if level==TREE_DEPTH, go to DONE; else level++ and go to READ.
- DONE: done=1 for one cycle, then IDLE.
- Latency with st_ready=1 throughout: each level costs 2+K cycles plus one cycle per stalled handshake. An empty path at default parameters puts done high in cycle 1+5*13 = 66 after the accept edge.
- Order of tuples on the stream: root first, then by increasing level; within a bucket, by increasing k.
- Reset mid-walk: the walk is abandoned immediately.
  - No further memory accesses are issued.
  - st_valid drops on the reset edge.
  - No done pulse is produced.

Optional Feature:
- Macro CLEAR_ON_READ_EN.
- Defined:
  - After SCAN of each level, a CLEAR state drives mem_wr_en=1, mem_addr = the same node, mem_wr_data=0 for one cycle.
  - Per-level cost becomes 3+K. Empty-path done lands in cycle 79.
- Undefined:
  - No CLEAR state exists; mem_wr_en and mem_wr_data are constant 0.
  - The tree is left intact for a separate write-back stage.

Test Plan:
- Empty tree, leaf=0x000, st_ready=1:
  - Read addresses 0,1,3,7,…,4095 (2^l − 1).
  - No st_valid; done in cycle 66; busy high in cycles 1–66.
- Empty tree, leaf=0xFFF: read addresses 0,2,6,…,8190 (2^(l+1) − 2).
- Leaf=0xA5C; node 0 tuple1={1,0x012,0x345,0xDEADBEEF}; leaf-level node 6747 tuple0 and tuple2 valid; everything else empty:
  - Exactly 3 stash transfers, in order node0.t1, node6747.t0, node6747.t2, with exact fields.
  - done in cycle 66.
- Same as the previous scenario, with st_ready low for 4 cycles on each valid tuple:
  - Fields held stable while stalled.
  - done in cycle 78.
- rst asserted during SCAN at level 5:
  - Next cycle: IDLE, req_ready=1, all outputs 0, no done.
  - A fresh request then completes normally.
- CLEAR_ON_READ_EN defined, leaf=0x000:
  - Each read of node n is followed 5 cycles later by mem_wr_en with mem_addr=n and data 0.
  - A second fetch of the same path returns no tuples; done in cycle 79.
